// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin chute front end: sync, debounce, classify, lockout, count
// Emits one-cycle coin codes for the vending FSM; reject flags refused or ambiguous insertions.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sense_5,
   input  logic       sense_10,
   input  logic       enable,
   output logic [1:0] coin,
   output logic       reject,
   output logic       busy,
   output logic [7:0] coin_count
);

   localparam int DW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int INIT_CYCLES = DEBOUNCE_CYCLES + 2;
   localparam int CNT_MAX     = (INIT_CYCLES > LOCKOUT_CYCLES) ? INIT_CYCLES : LOCKOUT_CYCLES;
   localparam int CW          = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOCKOUT, S_WAIT_CLEAR} state_t;

   // Bit 0 carries the 5-rupee sensor, bit 1 the 10-rupee sensor.
   logic [1:0]    raw;
   logic [1:0]    sync1_q, sync2_q, filt_q, filt_dly_q, rise;
   logic [DW-1:0] deb_cnt_q [2];

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    coin_q, coin_d;
   logic          reject_q, reject_d;
   logic [7:0]    count_q, count_d;

   assign raw  = {sense_10, sense_5};
   assign rise = filt_q & ~filt_dly_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         filt_q       <= '0;
         filt_dly_q   <= '0;
         deb_cnt_q[0] <= '0;
         deb_cnt_q[1] <= '0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         filt_dly_q <= filt_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
               if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                  filt_q[i]    <= sync2_q[i];
                  deb_cnt_q[i] <= '0;
               end else begin
                  deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
               end
            end else begin
               deb_cnt_q[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_INIT;
         cnt_q    <= '0;
         coin_q   <= 2'b00;
         reject_q <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         coin_q   <= coin_d;
         reject_q <= reject_d;
         count_q  <= count_d;
      end
   end

   // INIT always passes through WAIT_CLEAR so a sensor held across reset cannot count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            if (cnt_q == CW'(INIT_CYCLES - 1)) begin
               state_d = S_WAIT_CLEAR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (|rise) begin
               state_d = S_LOCKOUT;
               cnt_d   = '0;
            end
         end
         S_LOCKOUT: begin
            if (cnt_q == CW'(LOCKOUT_CYCLES - 1)) begin
               state_d = S_WAIT_CLEAR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (filt_q == 2'b00) state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      coin_d   = 2'b00;
      reject_d = 1'b0;
      count_d  = count_q;
      if (state_q == S_IDLE && (|rise)) begin
         if (enable && rise != 2'b11) begin
            coin_d = rise;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
         end else begin
            reject_d = 1'b1;
         end
      end
   end

   assign coin       = coin_q;
   assign reject     = reject_q;
   assign busy       = (state_q != S_IDLE);
   assign coin_count = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor
// Expected pulses are queued with their due cycle when a sensor is driven and popped when seen.
module tb_coin_acceptor;

   localparam int D = 4;
   localparam int L = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sense_5 = 1'b0;
   logic       sense_10 = 1'b0;
   logic       enable = 1'b1;
   logic [1:0] coin;
   logic       reject;
   logic       busy;
   logic [7:0] coin_count;

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
      .clk(clk), .reset(reset), .sense_5(sense_5), .sense_10(sense_10),
      .enable(enable), .coin(coin), .reject(reject), .busy(busy),
      .coin_count(coin_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] kind;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   model_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // kind = {reject, coin}
   always @(negedge clk) begin
      if (coin != 2'b00 || reject) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", int'({reject, coin}), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_kind", int'({reject, coin}), int'(e.kind));
            check("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic expect_pulse(input logic [2:0] kind);
      sb.push_back('{kind, cyc + 3 + D});
      if (kind[1:0] != 2'b00 && model_count < 255) model_count++;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!busy) return;
         @(negedge clk);
      end
      check("idle_timeout", int'(busy), 0);
   endtask

   task automatic insert(input logic s5, input logic s10, input int hold, input logic [2:0] kind);
      @(negedge clk);
      sense_5  = s5;
      sense_10 = s10;
      if (kind != 3'b000) expect_pulse(kind);
      repeat (hold) @(negedge clk);
      sense_5  = 1'b0;
      sense_10 = 1'b0;
      repeat (D + 4) @(negedge clk);
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      @(negedge clk);
      check("rst_coin", int'(coin), 0);
      check("rst_reject", int'(reject), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_count", int'(coin_count), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("init_busy", int'(busy), 1);
      wait_idle();

      // clean 5-rupee coin with exact busy timing
      @(negedge clk);
      n0 = cyc;
      sense_5 = 1'b1;
      expect_pulse(3'b001);
      repeat (D + 2) @(negedge clk);
      check("t1_busy_before", int'(busy), 0);
      @(negedge clk);
      check("t1_busy_lock", int'(busy), 1);
      repeat (3) @(negedge clk);
      sense_5 = 1'b0;
      repeat (6) @(negedge clk);
      check("t1_busy_clear", int'(busy), 1);
      @(negedge clk);
      check("t1_busy_idle", int'(busy), 0);
      check("t1_elapsed", cyc - n0, 17);
      check("t1_count", int'(coin_count), model_count);

      // short glitch is filtered, then a clean 10-rupee coin
      insert(1'b0, 1'b1, 2, 3'b000);
      check("t2_glitch_count", int'(coin_count), model_count);
      check("t2_glitch_busy", int'(busy), 0);
      insert(1'b0, 1'b1, 10, 3'b010);
      check("t2_count", int'(coin_count), model_count);

      // both sensors together
      insert(1'b1, 1'b1, 10, 3'b100);
      check("t3_count", int'(coin_count), model_count);

      // refused while disabled, accepted when enabled
      enable = 1'b0;
      insert(1'b1, 1'b0, 10, 3'b100);
      check("t4_disabled_count", int'(coin_count), model_count);
      enable = 1'b1;
      insert(1'b1, 1'b0, 10, 3'b001);
      check("t4_count", int'(coin_count), model_count);

      // second coin inside lockout, held until long after lockout
      @(negedge clk);
      sense_5 = 1'b1;
      expect_pulse(3'b001);
      repeat (D + 6) @(negedge clk);
      sense_5  = 1'b0;
      sense_10 = 1'b1;
      repeat (25) @(negedge clk);
      check("t5_held_busy", int'(busy), 1);
      sense_10 = 1'b0;
      repeat (D + 4) @(negedge clk);
      wait_idle();
      check("t5_held_count", int'(coin_count), model_count);
      insert(1'b0, 1'b1, 10, 3'b010);
      check("t5_count", int'(coin_count), model_count);

      // sensor held high through reset release
      @(negedge clk);
      sense_5 = 1'b1;
      reset = 1'b1;
      model_count = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("t5_rst_busy", int'(busy), 1);
      check("t5_rst_count", int'(coin_count), 0);
      sense_5 = 1'b0;
      repeat (D + 4) @(negedge clk);
      wait_idle();
      check("t5_rst_idle", int'(busy), 0);

      // saturation
      for (int i = 0; i < 260; i++) begin
         if (i % 2 == 0) insert(1'b1, 1'b0, 6, 3'b001);
         else            insert(1'b0, 1'b1, 6, 3'b010);
      end
      check("t6_sat_count", int'(coin_count), 255);
      check("t6_model_count", int'(coin_count), model_count);

      // reset in the middle of debounce
      @(negedge clk);
      sense_5 = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      model_count = 0;
      check("t6_rst_coin", int'(coin), 0);
      check("t6_rst_reject", int'(reject), 0);
      check("t6_rst_busy", int'(busy), 1);
      check("t6_rst_count", int'(coin_count), 0);
      @(negedge clk);
      sense_5 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (D + 4) @(negedge clk);
      wait_idle();
      check("end_busy", int'(busy), 0);
      check("end_count", int'(coin_count), 0);
      repeat (20) @(negedge clk);
      check("end_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
